// File: rtl/ekf_pkg.sv
// Shared types and width helpers for the sequential EKF update engine.
package ekf_pkg;

  // Engine phases: capture, per-lane divide, per-lane update, result hold.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } ekf_state_e;

  // Lane counter width for 2*m interleaved real/imaginary lanes.
  function automatic int lane_w(input int m);
    return (m > 1) ? $clog2(2 * m) : 1;
  endfunction

  // Width of p + r and of the innovation z - xp.
  function automatic int wp1(input int w);
    return w + 1;
  endfunction

  // Width of the filtered outputs.
  function automatic int w2(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/ekf_frac_div.sv
// Restoring fractional divider: q = floor(num * 2^FRAC_W / den), one bit per cycle.
// start marks the first of FRAC_W iteration cycles; done is high during the final
// iteration cycle, so q and degenerate are valid from the following cycle on.
// A lane is degenerate when num < 0, den == 0 or den < num (the measurement noise
// was negative); its quotient is forced to 0 but it still takes FRAC_W cycles.
module ekf_frac_div
  import ekf_pkg::*;
#(
  parameter int W      = 16,
  parameter int FRAC_W = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] num,
  input  logic signed [W:0]   den,
  output logic [FRAC_W-1:0]   q,
  output logic                done,
  output logic                degenerate
);

  localparam int CW = $clog2(FRAC_W + 1);

  logic [CW-1:0]     cnt;
  logic [W+1:0]      rem;
  logic [W+1:0]      src;
  logic [W+1:0]      trial;
  logic [W+1:0]      den_ext;
  logic [FRAC_W-1:0] q_raw;
  logic signed [W:0] num_ext;
  logic              q_bit;
  logic              degen_now;
  logic              degen_q;
  logic              busy;

  // One restoring step: on start the step works straight from num.
  always_comb begin
    num_ext   = num;
    degen_now = num[W-1] || (den == '0) || (den < num_ext);
    src       = start ? {2'b00, num} : rem;
    trial     = src << 1;
    den_ext   = {1'b0, den};
    q_bit     = (trial >= den_ext);
  end

  assign busy       = (cnt != CW'(FRAC_W));
  assign done       = start ? (FRAC_W == 1) : (cnt == CW'(FRAC_W - 1));
  assign q          = degen_q ? '0 : q_raw;
  assign degenerate = degen_q;

  // Iteration counter, partial remainder and quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CW'(FRAC_W);
      rem     <= '0;
      q_raw   <= '0;
      degen_q <= 1'b0;
    end else if (start || busy) begin
      cnt   <= start ? CW'(1) : cnt + CW'(1);
      rem   <= q_bit ? (trial - den_ext) : trial;
      q_raw <= {q_raw[FRAC_W-2:0], q_bit};
      if (start) degen_q <= degen_now;
    end
  end

endmodule

// File: rtl/ekf_seq_update.sv
// Sequential EKF measurement update over diagonal P/R, one real or imaginary lane
// at a time, sharing a single fractional divider and one multiply-round-add path.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the input bundle is taken only when in_ready (IDLE), and a result stays
// presented with out_valid high and unchanged until out_ready is seen.
module ekf_seq_update
  import ekf_pkg::*;
#(
  parameter int N      = 6,
  parameter int M      = 3,
  parameter int W      = 16,
  parameter int FRAC_W = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*W-1:0]      xp_re,
  input  logic [N*W-1:0]      xp_im,
  input  logic [N*W-1:0]      p_re,
  input  logic [N*W-1:0]      p_im,
  input  logic [M*W-1:0]      z_re,
  input  logic [M*W-1:0]      z_im,
  input  logic [M*W-1:0]      r_re,
  input  logic [M*W-1:0]      r_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*2*W-1:0]    xf_re,
  output logic [N*2*W-1:0]    xf_im,
  output logic [N*2*W-1:0]    pf_re,
  output logic [N*2*W-1:0]    pf_im,
  output logic                err,
  output ekf_state_e          state_dbg
);

  localparam int LW = lane_w(M);
  localparam int W1 = wp1(W);
  localparam int W2 = w2(W);
  localparam int PW = FRAC_W + W2;
  localparam logic [LW-1:0] LAST_LANE = LW'(2 * M - 1);

  ekf_state_e state, state_n;
  logic [LW-1:0] lane, lane_idx;
  logic          div_first, div_start, div_done, div_degen, accept;
  logic [FRAC_W-1:0] div_q;

  logic [M*W-1:0] cap_xp_re, cap_xp_im, cap_p_re, cap_p_im;
  logic [M*W-1:0] cap_z_re, cap_z_im, cap_r_re, cap_r_im;

  logic signed [W-1:0]  cur_xp, cur_p, cur_z, cur_r;
  logic signed [W1-1:0] p_x, r_x, xp_x, z_x, den_w, innov;
  logic signed [PW-1:0] k_e, innov_e, p_e, rnd, sum_x, sum_p;
  logic signed [W2-1:0] xp_w2, p_w2, xf_new, pf_new;
  logic                 unused_round_bits;

  assign state_dbg = state;
  assign accept    = in_valid && (state == IDLE);
  assign div_start = (state == DIV) && div_first;
  assign lane_idx  = lane >> 1;

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_n = LOAD;
      LOAD:    state_n = DIV;
      DIV:     if (div_done) state_n = UPD;
      UPD:     state_n = (lane == LAST_LANE) ? DONE : DIV;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, lane counter and divider-start marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane      <= '0;
      div_first <= 1'b0;
    end else begin
      state     <= state_n;
      div_first <= (state_n == DIV) && (state != DIV);
      if (state == LOAD) lane <= '0;
      else if (state == UPD && lane != LAST_LANE) lane <= lane + LW'(1);
    end
  end

  // Capture the observed part of the bundle; inputs may change after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_xp_re <= '0; cap_xp_im <= '0; cap_p_re <= '0; cap_p_im <= '0;
      cap_z_re  <= '0; cap_z_im  <= '0; cap_r_re <= '0; cap_r_im <= '0;
    end else if (accept) begin
      cap_xp_re <= xp_re[M*W-1:0]; cap_xp_im <= xp_im[M*W-1:0];
      cap_p_re  <= p_re[M*W-1:0];  cap_p_im  <= p_im[M*W-1:0];
      cap_z_re  <= z_re; cap_z_im <= z_im; cap_r_re <= r_re; cap_r_im <= r_im;
    end
  end

  // Per-lane operand mux and the shared multiply-round-add update path.
  always_comb begin
    if (lane[0]) begin
      cur_xp = cap_xp_im[lane_idx*W +: W]; cur_p = cap_p_im[lane_idx*W +: W];
      cur_z  = cap_z_im[lane_idx*W +: W];  cur_r = cap_r_im[lane_idx*W +: W];
    end else begin
      cur_xp = cap_xp_re[lane_idx*W +: W]; cur_p = cap_p_re[lane_idx*W +: W];
      cur_z  = cap_z_re[lane_idx*W +: W];  cur_r = cap_r_re[lane_idx*W +: W];
    end
    p_x   = cur_p;
    r_x   = cur_r;
    xp_x  = cur_xp;
    z_x   = cur_z;
    den_w = p_x + r_x;
    innov = z_x - xp_x;
    k_e   = '0;
    k_e[FRAC_W-1:0] = div_q;
    innov_e = innov;
    p_e     = cur_p;
    rnd     = '0;
    rnd[FRAC_W-1] = 1'b1;
    sum_x   = k_e * innov_e + rnd;
    sum_p   = k_e * p_e + rnd;
    xp_w2   = cur_xp;
    p_w2    = cur_p;
    // Taking the bits above FRAC_W is the arithmetic right shift.
    xf_new  = xp_w2 + sum_x[PW-1:FRAC_W];
    pf_new  = p_w2 - sum_p[PW-1:FRAC_W];
  end

  assign unused_round_bits = ^{sum_x[FRAC_W-1:0], sum_p[FRAC_W-1:0]};

  ekf_frac_div #(.W(W), .FRAC_W(FRAC_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (div_start),
    .num        (cur_p),
    .den        (den_w),
    .q          (div_q),
    .done       (div_done),
    .degenerate (div_degen)
  );

  // Result registers: unobserved states pass through at accept, lanes at UPD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xf_re <= '0; xf_im <= '0; pf_re <= '0; pf_im <= '0;
    end else if (accept) begin
      for (int k = M; k < N; k++) begin
        xf_re[k*W2 +: W2] <= {{W{xp_re[k*W+W-1]}}, xp_re[k*W +: W]};
        xf_im[k*W2 +: W2] <= {{W{xp_im[k*W+W-1]}}, xp_im[k*W +: W]};
        pf_re[k*W2 +: W2] <= {{W{p_re[k*W+W-1]}}, p_re[k*W +: W]};
        pf_im[k*W2 +: W2] <= {{W{p_im[k*W+W-1]}}, p_im[k*W +: W]};
      end
    end else if (state == UPD) begin
      if (lane[0]) begin
        xf_im[lane_idx*W2 +: W2] <= xf_new;
        pf_im[lane_idx*W2 +: W2] <= pf_new;
      end else begin
        xf_re[lane_idx*W2 +: W2] <= xf_new;
        pf_re[lane_idx*W2 +: W2] <= pf_new;
      end
    end
  end

  // Sticky degenerate-gain flag, cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == UPD && div_degen) err <= 1'b1;
    else if (state == DONE && out_ready) err <= 1'b0;
  end

endmodule

// File: tb/tb_ekf_seq_update.sv
// Bench for ekf_seq_update: default configuration plus an all-observed 8x8, W=24 build.
module tb_ekf_seq_update;
  import ekf_pkg::*;

  localparam int NA = 6, MA = 3, WA = 16;
  localparam int NB = 8, MB = 8, WB = 24;
  localparam int FW = 15;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_a;
  logic [NA*WA-1:0] xp_re_a, xp_im_a, p_re_a, p_im_a;
  logic [MA*WA-1:0] z_re_a, z_im_a, r_re_a, r_im_a;
  logic [NA*2*WA-1:0] xf_re_a, xf_im_a, pf_re_a, pf_im_a;
  ekf_state_e state_a;

  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_b;
  logic [NB*WB-1:0] xp_re_b, xp_im_b, p_re_b, p_im_b;
  logic [MB*WB-1:0] z_re_b, z_im_b, r_re_b, r_im_b;
  logic [NB*2*WB-1:0] xf_re_b, xf_im_b, pf_re_b, pf_im_b;
  ekf_state_e state_b;

  ekf_seq_update #(.N(NA), .M(MA), .W(WA), .FRAC_W(FW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .xp_re(xp_re_a), .xp_im(xp_im_a), .p_re(p_re_a), .p_im(p_im_a),
    .z_re(z_re_a), .z_im(z_im_a), .r_re(r_re_a), .r_im(r_im_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .xf_re(xf_re_a), .xf_im(xf_im_a), .pf_re(pf_re_a), .pf_im(pf_im_a),
    .err(err_a), .state_dbg(state_a));

  ekf_seq_update #(.N(NB), .M(MB), .W(WB), .FRAC_W(FW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .xp_re(xp_re_b), .xp_im(xp_im_b), .p_re(p_re_b), .p_im(p_im_b),
    .z_re(z_re_b), .z_im(z_im_b), .r_re(r_re_b), .r_im(r_im_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .xf_re(xf_re_b), .xf_im(xf_im_b), .pf_re(pf_re_b), .pf_im(pf_im_b),
    .err(err_b), .state_dbg(state_b));

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  bit exp_err;
  longint xp_re_v[8], xp_im_v[8], p_re_v[8], p_im_v[8];
  longint z_re_v[8], z_im_v[8], r_re_v[8], r_im_v[8];

  task automatic check(input string tag, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, expv);
    end
  endtask

  function automatic longint pop_exp();
    if (exp_q.size() == 0) return -(longint'(1) <<< 50);
    return longint'(exp_q.pop_front());
  endfunction

  // Reference: one Kalman update on a scalar lane with a Q0.FW gain.
  function automatic void model_lane(input longint xp, input longint p, input longint z,
                                     input longint r, output longint xf, output longint pf,
                                     output bit dg);
    longint k, rnd;
    rnd = longint'(1) <<< (FW - 1);
    dg  = (p < 0) || (r < 0) || (p + r == 0);
    if (dg) k = 0;
    else begin
      k = (p * (longint'(1) <<< FW)) / (p + r);
      if (k > (longint'(1) <<< FW) - 1) k = (longint'(1) <<< FW) - 1;
    end
    xf = xp + ((k * (z - xp) + rnd) >>> FW);
    pf = p - ((k * p + rnd) >>> FW);
  endfunction

  task automatic build_expect(input int n, input int m);
    longint xp, p, z, r, xf, pf;
    bit dg;
    exp_err = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int im = 0; im < 2; im++) begin
        xp = im ? xp_im_v[k] : xp_re_v[k];
        p  = im ? p_im_v[k]  : p_re_v[k];
        z  = im ? z_im_v[k]  : z_re_v[k];
        r  = im ? r_im_v[k]  : r_re_v[k];
        if (k < m) begin
          model_lane(xp, p, z, r, xf, pf, dg);
          exp_err |= dg;
        end else begin
          xf = xp;
          pf = p;
        end
        exp_q.push_back(xf);
        exp_q.push_back(pf);
      end
    end
  endtask

  function automatic longint rs(input int w);
    return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w - 1));
  endfunction

  task automatic rand_bundle(input int w);
    int mx;
    mx = (1 << (w - 1)) - 1;
    for (int k = 0; k < 8; k++) begin
      xp_re_v[k] = rs(w); xp_im_v[k] = rs(w); z_re_v[k] = rs(w); z_im_v[k] = rs(w);
      p_re_v[k] = ($urandom_range(0, 9) == 0) ? -longint'($urandom_range(1, mx)) : longint'($urandom_range(0, mx));
      p_im_v[k] = ($urandom_range(0, 9) == 0) ? -longint'($urandom_range(1, mx)) : longint'($urandom_range(0, mx));
      r_re_v[k] = ($urandom_range(0, 7) == 0) ? -longint'($urandom_range(1, mx)) : longint'($urandom_range(1, mx));
      r_im_v[k] = ($urandom_range(0, 7) == 0) ? -longint'($urandom_range(1, mx)) : longint'($urandom_range(1, mx));
    end
  endtask

  task automatic set_base();
    for (int k = 0; k < 8; k++) begin
      xp_re_v[k] = 0; xp_im_v[k] = 0; p_re_v[k] = 0; p_im_v[k] = 0;
      z_re_v[k] = 0; z_im_v[k] = 0; r_re_v[k] = 1; r_im_v[k] = 1;
    end
    xp_re_v[0] = 100;  z_re_v[0] = 105;  p_re_v[0] = 40;   r_re_v[0] = 10;
    xp_im_v[0] = 90;   z_im_v[0] = 95;   p_im_v[0] = 60;   r_im_v[0] = 12;
    xp_re_v[1] = 77;   z_re_v[1] = 50;   p_re_v[1] = 40;   r_re_v[1] = 30;
    xp_im_v[1] = -20;  z_im_v[1] = 33;   p_im_v[1] = 15;   r_im_v[1] = 5;
    xp_re_v[2] = -300; z_re_v[2] = -280; p_re_v[2] = 1000; r_re_v[2] = 200;
    xp_im_v[2] = 5;    z_im_v[2] = 5;    p_im_v[2] = 0;    r_im_v[2] = 9;
    xp_re_v[3] = 130;  xp_re_v[4] = 140; xp_re_v[5] = 150;
    p_re_v[3] = 40;    p_re_v[4] = 40;   p_re_v[5] = 40;
    xp_im_v[3] = -1;   xp_im_v[4] = -2;  xp_im_v[5] = -3;
    p_im_v[3] = 7;     p_im_v[4] = 7;    p_im_v[5] = 7;
  endtask

  // Driver tasks
  task automatic drive_a();
    for (int k = 0; k < NA; k++) begin
      xp_re_a[k*WA +: WA] = xp_re_v[k][WA-1:0]; xp_im_a[k*WA +: WA] = xp_im_v[k][WA-1:0];
      p_re_a[k*WA +: WA]  = p_re_v[k][WA-1:0];  p_im_a[k*WA +: WA]  = p_im_v[k][WA-1:0];
    end
    for (int k = 0; k < MA; k++) begin
      z_re_a[k*WA +: WA] = z_re_v[k][WA-1:0]; z_im_a[k*WA +: WA] = z_im_v[k][WA-1:0];
      r_re_a[k*WA +: WA] = r_re_v[k][WA-1:0]; r_im_a[k*WA +: WA] = r_im_v[k][WA-1:0];
    end
  endtask

  task automatic drive_b();
    for (int k = 0; k < NB; k++) begin
      xp_re_b[k*WB +: WB] = xp_re_v[k][WB-1:0]; xp_im_b[k*WB +: WB] = xp_im_v[k][WB-1:0];
      p_re_b[k*WB +: WB]  = p_re_v[k][WB-1:0];  p_im_b[k*WB +: WB]  = p_im_v[k][WB-1:0];
      z_re_b[k*WB +: WB]  = z_re_v[k][WB-1:0];  z_im_b[k*WB +: WB]  = z_im_v[k][WB-1:0];
      r_re_b[k*WB +: WB]  = r_re_v[k][WB-1:0];  r_im_b[k*WB +: WB]  = r_im_v[k][WB-1:0];
    end
  endtask

  task automatic compare_a();
    for (int k = 0; k < NA; k++) begin
      check($sformatf("a_xf_re%0d", k), longint'($signed(xf_re_a[k*2*WA +: 2*WA])), pop_exp());
      check($sformatf("a_pf_re%0d", k), longint'($signed(pf_re_a[k*2*WA +: 2*WA])), pop_exp());
      check($sformatf("a_xf_im%0d", k), longint'($signed(xf_im_a[k*2*WA +: 2*WA])), pop_exp());
      check($sformatf("a_pf_im%0d", k), longint'($signed(pf_im_a[k*2*WA +: 2*WA])), pop_exp());
    end
  endtask

  task automatic compare_b();
    for (int k = 0; k < NB; k++) begin
      check($sformatf("b_xf_re%0d", k), longint'($signed(xf_re_b[k*2*WB +: 2*WB])), pop_exp());
      check($sformatf("b_pf_re%0d", k), longint'($signed(pf_re_b[k*2*WB +: 2*WB])), pop_exp());
      check($sformatf("b_xf_im%0d", k), longint'($signed(xf_im_b[k*2*WB +: 2*WB])), pop_exp());
      check($sformatf("b_pf_im%0d", k), longint'($signed(pf_im_b[k*2*WB +: 2*WB])), pop_exp());
    end
  endtask

  task automatic accept_a();
    int g;
    g = 0;
    while (!in_ready_a && g < 50) begin @(posedge clk); #1; g++; end
    check("a_in_ready_idle", in_ready_a, 1);
    drive_a();
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    xp_re_a = ~xp_re_a; xp_im_a = ~xp_im_a; p_re_a = ~p_re_a; p_im_a = ~p_im_a;
    z_re_a = ~z_re_a; z_im_a = ~z_im_a; r_re_a = ~r_re_a; r_im_a = ~r_im_a;
  endtask

  // One full transaction on the default build; optional stray in_valid pulse while busy.
  task automatic run_a(input int hold, input bit pulse);
    int lat;
    build_expect(NA, MA);
    accept_a();
    check("a_in_ready_busy", in_ready_a, 0);
    lat = 0;
    while (!out_valid_a && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      in_valid_a = pulse && (lat == 30);
    end
    in_valid_a = 1'b0;
    check("a_latency", lat, 1 + 2 * MA * (FW + 1));
    repeat (hold) begin @(posedge clk); #1; end
    check("a_valid_held", out_valid_a, 1);
    check("a_in_ready_done", in_ready_a, 0);
    compare_a();
    check("a_err", err_a, longint'(exp_err));
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    check("a_valid_drop", out_valid_a, 0);
    check("a_err_clear", err_a, 0);
    check("a_in_ready_back", in_ready_a, 1);
  endtask

  task automatic run_b(input int hold);
    int lat, g;
    build_expect(NB, MB);
    g = 0;
    while (!in_ready_b && g < 50) begin @(posedge clk); #1; g++; end
    check("b_in_ready_idle", in_ready_b, 1);
    drive_b();
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    xp_re_b = ~xp_re_b; p_re_b = ~p_re_b; z_re_b = ~z_re_b; r_im_b = ~r_im_b;
    lat = 0;
    while (!out_valid_b && lat < 400) begin @(posedge clk); #1; lat++; end
    check("b_latency", lat, 1 + 2 * MB * (FW + 1));
    repeat (hold) begin @(posedge clk); #1; end
    compare_b();
    check("b_err", err_b, longint'(exp_err));
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    check("b_valid_drop", out_valid_b, 0);
    check("b_err_clear", err_b, 0);
  endtask

  task automatic check_reset_state();
    check("rst_a_in_ready", in_ready_a, 1);
    check("rst_a_out_valid", out_valid_a, 0);
    check("rst_a_err", err_a, 0);
    check("rst_a_outs_zero", longint'(|{xf_re_a, xf_im_a, pf_re_a, pf_im_a}), 0);
    check("rst_b_out_valid", out_valid_b, 0);
    check("rst_b_outs_zero", longint'(|{xf_re_b, xf_im_b, pf_re_b, pf_im_b}), 0);
  endtask

  initial begin
    in_valid_a = 0; out_ready_a = 0; in_valid_b = 0; out_ready_b = 0;
    xp_re_a = '0; xp_im_a = '0; p_re_a = '0; p_im_a = '0;
    z_re_a = '0; z_im_a = '0; r_re_a = '0; r_im_a = '0;
    xp_re_b = '0; xp_im_b = '0; p_re_b = '0; p_im_b = '0;
    z_re_b = '0; z_im_b = '0; r_re_b = '0; r_im_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed bundle with pass-through states; result held 20 cycles, stray in_valid pulse.
    set_base();
    run_a(20, 1'b1);
    check("t1_xf_re0", longint'($signed(xf_re_a[0 +: 32])), 104);
    check("t1_pf_re0", longint'($signed(pf_re_a[0 +: 32])), 8);
    check("t1_xf_im0", longint'($signed(xf_im_a[0 +: 32])), 94);
    check("t1_pf_im0", longint'($signed(pf_im_a[0 +: 32])), 10);
    check("t2_xf_re3", longint'($signed(xf_re_a[3*32 +: 32])), 130);
    check("t2_xf_re5", longint'($signed(xf_re_a[5*32 +: 32])), 150);
    check("t2_pf_re4", longint'($signed(pf_re_a[4*32 +: 32])), 40);

    // Degenerate lane: p + r == 0.
    set_base();
    r_re_v[1] = -40;
    run_a(2, 1'b0);
    check("t3_xf_re1", longint'($signed(xf_re_a[1*32 +: 32])), 77);
    check("t3_pf_re1", longint'($signed(pf_re_a[1*32 +: 32])), 40);

    // Negative innovation.
    set_base();
    z_re_v[0] = 90;
    run_a(0, 1'b0);
    check("t5_xf_re0", longint'($signed(xf_re_a[0 +: 32])), 92);

    // Reset while lane 3 (im1) is dividing.
    rand_bundle(WA);
    accept_a();
    repeat (1 + 3 * (FW + 1) + 4) @(posedge clk);
    #1;
    check("abort_state", longint'(state_a), longint'(DIV));
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 12; t++) begin
      rand_bundle(WA);
      run_a($urandom_range(0, 3), 1'b0);
    end

    for (int t = 0; t < 4; t++) begin
      rand_bundle(WB);
      run_b($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
